// File: rtl/rr_bus_arbiter_8_pkg.sv
// Shared types, sizes and the rotating priority scan for the round-robin bus arbiter.
package rr_arb_pkg;

    localparam int NUM_REQ = 8;
    localparam int IDX_W   = 3;
    localparam int DATA_W  = 32;

    typedef enum logic {
        ARB  = 1'b0,
        XFER = 1'b1
    } arb_state_e;

    typedef struct packed {
        logic             found;
        logic [IDX_W-1:0] idx;
    } pick_t;

    // Scanning from the far end down means the last hit written is the one closest to ptr.
    function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req,
                                      input logic [IDX_W-1:0]   ptr);
        pick_t            p;
        logic [IDX_W-1:0] cand;
        p = '0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            cand = ptr + IDX_W'(k);
            if (req[cand]) begin
                p.found = 1'b1;
                p.idx   = cand;
            end
        end
        return p;
    endfunction

endpackage

// File: rtl/rr_bus_arbiter_8_if.sv
// Requester/consumer bundle of the round-robin arbiter; the lock input exists only
// when RR_ARB_LOCK_EN is defined.
interface rr_bus_arbiter_8_if;
    import rr_arb_pkg::*;

    logic [NUM_REQ-1:0] req;
    logic [DATA_W-1:0]  in0, in1, in2, in3, in4, in5, in6, in7;
    logic [NUM_REQ-1:0] grant;
    logic               out_valid;
    logic [DATA_W-1:0]  out_data;
    logic [IDX_W-1:0]   out_src;
    logic               out_ready;
`ifdef RR_ARB_LOCK_EN
    logic               lock;
`endif

    modport master (
`ifdef RR_ARB_LOCK_EN
        output lock,
`endif
        output req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        input  grant, out_valid, out_data, out_src
    );

    modport slave (
`ifdef RR_ARB_LOCK_EN
        input  lock,
`endif
        input  req, in0, in1, in2, in3, in4, in5, in6, in7, out_ready,
        output grant, out_valid, out_data, out_src
    );

endinterface

// File: rtl/rr_bus_arbiter_8_mux.sv
// mux_8: eight-way 32-bit word selector that feeds the shared datapath.
module mux_8
    import rr_arb_pkg::*;
(
    input  logic [DATA_W-1:0] in0,
    input  logic [DATA_W-1:0] in1,
    input  logic [DATA_W-1:0] in2,
    input  logic [DATA_W-1:0] in3,
    input  logic [DATA_W-1:0] in4,
    input  logic [DATA_W-1:0] in5,
    input  logic [DATA_W-1:0] in6,
    input  logic [DATA_W-1:0] in7,
    input  logic [IDX_W-1:0]  select,
    output logic [DATA_W-1:0] out
);

    always_comb begin
        out = in0;
        case (select)
            3'd1:    out = in1;
            3'd2:    out = in2;
            3'd3:    out = in3;
            3'd4:    out = in4;
            3'd5:    out = in5;
            3'd6:    out = in6;
            3'd7:    out = in7;
            default: out = in0;
        endcase
    end

endmodule

// File: rtl/rr_bus_arbiter_8.sv
// Round-robin arbiter handing the mux_8 datapath to one of eight requesters in bounded
// bursts. Define RR_ARB_LOCK_EN to let the owner extend its burst past MAX_BURST.
module rr_bus_arbiter_8
    import rr_arb_pkg::*;
#(
    parameter int MAX_BURST = 4
) (
    input  logic              clock,
    input  logic              reset_n,
    rr_bus_arbiter_8_if.slave bus
);

    localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

    arb_state_e         state_q, state_d;
    logic [IDX_W-1:0]   owner_q, owner_d;
    logic [IDX_W-1:0]   ptr_q, ptr_d;
    logic [3:0]         beat_cnt_q, beat_cnt_d;
    logic [NUM_REQ-1:0] grant_raw;
    logic               valid_raw;
    logic               valid_gated;
    logic               owner_req;
    logic               beat_fire;
    logic               lock_hit;
    logic [DATA_W-1:0]  mux_out;
    pick_t              pick;

`ifdef RR_ARB_LOCK_EN
    assign lock_hit = bus.lock;
`else
    assign lock_hit = 1'b0;
`endif

    mux_8 u_mux (
        .in0    (bus.in0),
        .in1    (bus.in1),
        .in2    (bus.in2),
        .in3    (bus.in3),
        .in4    (bus.in4),
        .in5    (bus.in5),
        .in6    (bus.in6),
        .in7    (bus.in7),
        .select (owner_q),
        .out    (mux_out)
    );

    assign pick      = rr_pick(bus.req, ptr_q);
    assign owner_req = bus.req[owner_q];
    assign beat_fire = (state_q == XFER) && owner_req && bus.out_ready;

    always_ff @(posedge clock) begin
        if (!reset_n) begin
            state_q    <= ARB;
            owner_q    <= '0;
            ptr_q      <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            ptr_q      <= ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

    // Moving ptr past the owner on every exit is what forces the owner to the back of the queue.
    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        ptr_d      = ptr_q;
        beat_cnt_d = beat_cnt_q;
        grant_raw  = '0;
        valid_raw  = 1'b0;
        case (state_q)
            ARB: begin
                if (pick.found) begin
                    owner_d    = pick.idx;
                    beat_cnt_d = '0;
                    state_d    = XFER;
                end
            end
            XFER: begin
                valid_raw          = owner_req;
                grant_raw[owner_q] = beat_fire;
                if (!owner_req) begin
                    ptr_d   = owner_q + 1'b1;
                    state_d = ARB;
                end else if (beat_fire) begin
                    if (beat_cnt_q == BURST_LAST && lock_hit) begin
                        beat_cnt_d = '0;
                    end else if (beat_cnt_q == BURST_LAST) begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                        ptr_d      = owner_q + 1'b1;
                        state_d    = ARB;
                    end else begin
                        beat_cnt_d = beat_cnt_q + 4'd1;
                    end
                end
            end
            default: state_d = ARB;
        endcase
    end

    // Handshake outputs are masked during reset so an abandoned burst never completes a beat.
    assign valid_gated   = reset_n & valid_raw;
    assign bus.grant     = reset_n ? grant_raw : '0;
    assign bus.out_valid = valid_gated;
    assign bus.out_data  = valid_gated ? mux_out : '0;
    assign bus.out_src   = owner_q;

endmodule

// File: doc/rr_bus_arbiter_8.md
# rr_bus_arbiter_8

- Round-robin arbiter that shares one 32-bit datapath, the `mux_8` word selector, among eight requesters.
- Sequences ownership and burst length, drives the selector, and presents a single valid/ready stream to the downstream consumer (register-file write port, board-state memory or I/O bus).
- Fair rotation guarantees bounded wait: at most 7 × (MAX_BURST + 1) beats/bubbles.

## Interface
- `MAX_BURST`, default 4: beats one owner may transfer per grant before forced rotation; legal range 1..15.
- `clock` — input, 1: single clock, rising edge.
- `reset_n` — input, 1: synchronous, active-low reset.
- `req` — input, 8: `req[i]` high means requester i has a valid word on `in_i`.
- `in0`..`in7` — input, 32 each: requester data words.
- `grant` — output, 8: one-hot; `grant[i]` high means requester i's word is consumed this cycle.
- `out_valid` — output, 1: downstream word valid.
- `out_data` — output, 32: selected word; 0 when `out_valid` is low.
- `out_src` — output, 3: index of the current owner.
- `out_ready` — input, 1: downstream accepts the word this cycle.
- `lock` — input, 1: present only with `RR_ARB_LOCK_EN`; owner extends its burst.

## Operation
- States: ARB, XFER. Registers: `owner[2:0]`, `ptr[2:0]` (next priority index), `beat_cnt[3:0]`.
- **ARB**
  - If `req` is nonzero, `owner` = first set bit scanning `ptr, ptr+1, … ptr+7`, mod 8.
  - `beat_cnt` ← 0; go to XFER.
  - Otherwise stay in ARB.
  - No grant, `out_valid` = 0.
- **XFER**
  - Selector index = `owner`; `out_src` = `owner`.
  - `out_valid` = `req[owner]`.
  - `grant[owner]` = `req[owner] & out_ready`; all other grant bits 0.
- **Beat accounting:** each granted beat increments `beat_cnt`.
- **XFER exit**, whichever applies first:
  - (a) `req[owner]` low (no transfer that cycle);
  - (b) a granted beat brings `beat_cnt` to `MAX_BURST`.
  - On exit: `ptr` ← `owner + 1` mod 8 (7 wraps to 0); next state ARB.
- **Stall:** `req[owner]` high with `out_ready` low holds XFER. There is no timeout and the count does not advance.
- **Simultaneous requests:** resolved purely by `ptr` order. A requester that drops `req` while not owner loses nothing.
- **Owner re-request:** the owner may re-win only after all other requesters at or after `ptr` are passed over.
- **Outputs gated:** `out_data` = `out_valid ? mux_out : 0`. `out_valid` and `grant` are forced to 0 while `reset_n` is low.

## Timing
- **Reset (next edge with `reset_n` low):**
  - State ARB; `owner`, `ptr`, `beat_cnt` = 0.
  - `grant` = 0, `out_valid` = 0, `out_data` = 0, `out_src` = 0.
- **Mid-burst reset:** abandons the burst with no grant in the reset cycle; the restart after reset is fair from index 0.
- **Latency:** `req` sampled in ARB at edge k → `out_valid` combinationally high in cycle k+1. The first grant comes in cycle k+1 at the earliest.
- **Throughput:** one beat per cycle inside a burst; exactly one idle (ARB) cycle between bursts.
- **Combinational paths:** `grant` and `out_valid` depend combinationally on `req` and `out_ready`. The consumer must not close a loop from `grant` back to `out_ready`.
- **Parameter edge case:** `MAX_BURST` = 1 gives strict per-beat rotation with alternating XFER/ARB.

## Configuration
- `RR_ARB_LOCK_EN` defined:
  - Adds the `lock` port.
  - If `lock` is high on the beat that would reach `MAX_BURST`, XFER continues and `beat_cnt` restarts at 0.
  - Release then occurs only via `req[owner]` low or a later unlocked limit.
- Undefined: no `lock` port; the burst limit is always enforced.

## Structure
- Shared package `rr_arb_pkg`:
  - State encoding: ARB = 1'b0, XFER = 1'b1.
  - `NUM_REQ` = 8, `IDX_W` = 3, `DATA_W` = 32.
  - Priority-scan function `rr_pick(req, ptr)` returning index and found flag.
- One sub-module: an instance of the existing `mux_8` with `select` = `owner` and inputs `in0`..`in7`. No other hierarchy.

## Test plan
- **Single requester:** reset, `req` = 8'b0000_0100, `out_ready` = 1 held.
  - `out_src` = 2; four grants; one ARB bubble; repeat.
  - `ptr` wraps, so requester 2 is regranted.
- **All-request fairness:** `req` = 8'hFF, `out_ready` = 1.
  - Owners 0,1,…,7,0 in order, 4 beats each.
  - `out_data` equals `in_owner` every granted beat.
- **Backpressure:** owner 5, toggle `out_ready` 1,0,0,1,1,1.
  - Grants only on ready cycles; burst ends after the 4th granted beat; data stable while stalled.
- **Early release:** owner 3 drops `req` after 2 beats.
  - XFER exits; next owner is the lowest set index from 4 upward, e.g. `req` = 8'h01 gives owner 0 via wrap.
- **Reset mid-burst:** `reset_n` low during owner 6's 2nd beat.
  - Same-cycle `grant` = 0, `out_valid` = 0; after release with `req` = 8'hC1, owner 0.
- **Lock** (`RR_ARB_LOCK_EN`): `lock` = 1, owner 1 with `req` held.
  - 10 consecutive beats, no rotation; `lock` = 0 → exit at the next 4-beat boundary.
